tipi_nib_seq: RTL and testbench
===============================

TIPI_NIB_SEQ -- requirements
Module: tipi_nib_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for all Pi-side inputs, legal 2..3.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: idle clk cycles tolerated mid-frame, legal 16..65535.
REQ-003 SHALL provide ports, clock and reset first; bit 0 is MSB on every vector:
  clk  in  1  free-running CPLD clock, the block's only clock.
  reset_n  in  1  asynchronous, active-low reset.
  r_clk  in  1  Pi nibble strobe, asynchronous to clk.
  r_nibrst  in  1  Pi frame reset, asynchronous, active high.
  r_nib_in  in  [0:3]  nibble driven by Pi.
  r_nib_out  out  [0:3]  nibble driven to Pi.
  r_nib_oe  out  1  high = CPLD drives r_nib pads.
  td_in  in  [0:7]  TD latch contents.
  tc_in  in  [0:7]  TC latch contents.
  rd_out  out  [0:7]  RD register presented to the TI.
  rc_out  out  [0:7]  RC register presented to the TI.
  rx_commit  out  1  one-clk pulse when RD/RC update.
  busy  out  1  frame in progress.
  timeout_err  out  1  sticky frame-timeout flag.

Function
REQ-004 SHALL pass r_clk, r_nibrst and r_nib_in through identical SYNC_STAGES flop chains; all decisions use synchronised copies only.
REQ-005 SHALL detect r_clk rising edge as synced-high with previous synced-low; edge event is one clk wide.
REQ-006 SHALL implement states IDLE, SLOT0..SLOT7; any synced r_nibrst high forces SLOT0 next clk, from any state.
REQ-007 SHALL, on entering SLOT0, snapshot td_in and tc_in into tx shadows; slots 0-3 transmit TD[0:3], TD[4:7], TC[0:3], TC[4:7] from the shadows.
REQ-008 SHALL advance one slot per r_clk edge; SLOT7 edge wraps to SLOT0 with a new snapshot. Edges in IDLE are ignored.
REQ-009 SHALL assert r_nib_oe and a valid r_nib_out exactly 1 clk after entering SLOT0..SLOT3; in all other states r_nib_oe = 0 and r_nib_out = 0000.
REQ-010 SHALL, on the edge leaving SLOT4..SLOT7, capture synced r_nib_in into rx shadow: RD hi, RD lo, RC hi, RC lo.
REQ-011 SHALL copy the rx shadow to rd_out/rc_out atomically and pulse rx_commit on the clk after the SLOT7 edge; partial frames never alter rd_out/rc_out.
REQ-012 SHALL treat r_nibrst and an r_clk edge in the same clk as r_nibrst only; the rx shadow is discarded.
REQ-013 SHALL drive busy = 1 in SLOT0..SLOT7 and 0 in IDLE.

Reset
REQ-014 SHALL, on reset_n low, asynchronously clear: state IDLE; rd_out, rc_out, shadows = 00h; r_nib_oe, rx_commit, busy, timeout_err = 0; synchronisers = 0.
REQ-015 SHALL, after reset_n deasserts, stay in IDLE until a synced r_nibrst is seen.

Configuration
REQ-016 SHALL, with TIPI_NIB_TIMEOUT_EN defined, count clk cycles without an r_clk edge while busy; at TIMEOUT_CYCLES it forces IDLE, discards the rx shadow and sets timeout_err.
REQ-017 SHALL clear timeout_err on the next synced r_nibrst.
REQ-018 SHALL, without TIPI_NIB_TIMEOUT_EN, build no counter and tie timeout_err to 0.

Structure
REQ-019 SHALL take the state encoding, slot count (8) and nibble width (4) from the shared package tipi_pkg.
REQ-020 SHALL use one sub-module, tipi_sync, for the parameterised synchroniser chain; it is instantiated per input bit.

Verification
REQ-021 Reset, pulse r_nibrst, 8 r_clk edges with td_in=A5h, tc_in=3Ch, Pi nibbles 1,2,F,E -> r_nib_out sequence A,5,3,C; rd_out=12h, rc_out=FEh; one rx_commit.
REQ-022 r_nibrst after 6 edges, prior rd_out=12h -> rd_out/rc_out unchanged, state SLOT0, no rx_commit.
REQ-023 td_in changes 5Ah->FFh after SLOT0 entry -> Pi still reads 5,A for TD.
REQ-024 r_clk edges before any r_nibrst -> state stays IDLE, r_nib_oe=0, busy=0.
REQ-025 16 continuous edges after one r_nibrst -> two rx_commit pulses; second frame re-snapshots TD/TC.
REQ-026 TIPI_NIB_TIMEOUT_EN, TIMEOUT_CYCLES=16, stall 20 clk in SLOT5 -> IDLE, timeout_err=1, rd_out unchanged; next r_nibrst clears timeout_err.

Source files
------------

// File: rtl/tipi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tipi_pkg
// Purpose : Shared definitions for the TIPI nibble sequencer. It holds the
//           frame-state encoding, the slot count and the nibble width, plus a
//           helper that advances the slot counter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package tipi_pkg;

  localparam int unsigned SLOT_COUNT = 8;
  localparam int unsigned NIB_W      = 4;

  // ST_SLOTn is encoded as n+1, so ST_SLOT7 == SLOT_COUNT.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SLOT0 = 4'd1,
    ST_SLOT1 = 4'd2,
    ST_SLOT2 = 4'd3,
    ST_SLOT3 = 4'd4,
    ST_SLOT4 = 4'd5,
    ST_SLOT5 = 4'd6,
    ST_SLOT6 = 4'd7,
    ST_SLOT7 = 4'd8
  } state_t;

  // Next slot in the frame. The last slot wraps back to the first.
  function automatic state_t next_slot(input state_t s);
    if (s == state_t'(SLOT_COUNT)) begin
      return ST_SLOT0;
    end
    return state_t'(s + 4'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tipi_sync.sv
`default_nettype none
// ============================================================================
// Module  : tipi_sync
// Purpose : Single-bit multi-flop synchroniser for Pi-side signals. Each
//           signal that crosses from the Pi domain into clk gets one instance.
// Ports   : clk   - destination clock
//           rst_n - asynchronous active-low reset; clears the chain
//           d     - asynchronous input
//           q     - synchronised output
// Params  : STAGES - number of flops in the chain (2..3)
// Revision: 1.0 - initial release
// ============================================================================
module tipi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/tipi_nib_seq.sv
`default_nettype none
// ============================================================================
// Module  : tipi_nib_seq
// Purpose : TIPI Pi-side nibble sequencer. Each frame has eight nibble slots
//           that are clocked by the Pi strobe r_clk. Slots 0-3 send the TD and
//           TC latches to the Pi. Slots 4-7 collect RD and RC from the Pi, and
//           both bytes are committed together once the frame is complete.
// Ports   : clk, reset_n       - CPLD clock, async active-low reset
//           r_clk, r_nibrst    - Pi strobe / frame reset (asynchronous)
//           r_nib_in/out/oe    - Pi nibble bus (bit 0 = MSB)
//           td_in, tc_in       - bytes sent to the Pi
//           rd_out, rc_out     - bytes received from the Pi
//           rx_commit          - one-clk pulse when rd_out/rc_out update
//           busy, timeout_err  - frame active / sticky stall flag
// Config  : `define TIPI_NIB_TIMEOUT_EN to build the mid-frame stall timeout.
//           Without it, timeout_err is tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
module tipi_nib_seq
  import tipi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       r_clk,
  input  logic       r_nibrst,
  input  logic [0:3] r_nib_in,
  output logic [0:3] r_nib_out,
  output logic       r_nib_oe,
  input  logic [0:7] td_in,
  input  logic [0:7] tc_in,
  output logic [0:7] rd_out,
  output logic [0:7] rc_out,
  output logic       rx_commit,
  output logic       busy,
  output logic       timeout_err
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
      TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("tipi_nib_seq: SYNC_STAGES or TIMEOUT_CYCLES out of range");
  end

  // --------------------------------------------------------------------------
  // Synchronisers. Nothing below looks at the raw Pi pins.
  // --------------------------------------------------------------------------
  logic             w_rclk;
  logic             w_nibrst;
  logic [0:NIB_W-1] w_nib;

  tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_rclk (
    .clk(clk), .rst_n(reset_n), .d(r_clk), .q(w_rclk)
  );

  tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_nibrst (
    .clk(clk), .rst_n(reset_n), .d(r_nibrst), .q(w_nibrst)
  );

  for (genvar i = 0; i < NIB_W; i++) begin : g_nib_sync
    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_nib (
      .clk(clk), .rst_n(reset_n), .d(r_nib_in[i]), .q(w_nib[i])
    );
  end

  // Rising-edge detector on the synchronised strobe.
  logic rclk_prev_q;
  logic w_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rclk_prev_q <= 1'b0;
    end else begin
      rclk_prev_q <= w_rclk;
    end
  end

  assign w_edge = w_rclk & ~rclk_prev_q;

  // --------------------------------------------------------------------------
  // Frame FSM and datapath
  // --------------------------------------------------------------------------
  state_t           state_q;
  logic [0:7]       tx_td_q, tx_tc_q;
  logic [0:7]       rx_rd_q, rx_rc_q;
  logic [0:7]       rd_q, rc_q;
  logic [0:NIB_W-1] nib_out_q;
  logic             nib_oe_q;
  logic             commit_q;
  logic             busy_q;
`ifdef TIPI_NIB_TIMEOUT_EN
  logic [15:0]      idle_cnt_q;
  logic             terr_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tx_td_q    <= '0;
      tx_tc_q    <= '0;
      rx_rd_q    <= '0;
      rx_rc_q    <= '0;
      rd_q       <= '0;
      rc_q       <= '0;
      nib_out_q  <= '0;
      nib_oe_q   <= 1'b0;
      commit_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TIPI_NIB_TIMEOUT_EN
      idle_cnt_q <= '0;
      terr_q     <= 1'b0;
`endif
    end else begin
      commit_q <= 1'b0;

      // The pad outputs follow the state one clk late. The shadow they read
      // was loaded on the same edge that entered SLOT0.
      nib_oe_q <= (state_q inside {ST_SLOT0, ST_SLOT1, ST_SLOT2, ST_SLOT3});
      case (state_q)
        ST_SLOT0: nib_out_q <= tx_td_q[0:3];
        ST_SLOT1: nib_out_q <= tx_td_q[4:7];
        ST_SLOT2: nib_out_q <= tx_tc_q[0:3];
        ST_SLOT3: nib_out_q <= tx_tc_q[4:7];
        default:  nib_out_q <= '0;
      endcase

      if (w_nibrst) begin
        // Frame reset wins over a coincident strobe edge. A partial receive
        // is thrown away here.
        state_q    <= ST_SLOT0;
        busy_q     <= 1'b1;
        tx_td_q    <= td_in;
        tx_tc_q    <= tc_in;
        rx_rd_q    <= '0;
        rx_rc_q    <= '0;
`ifdef TIPI_NIB_TIMEOUT_EN
        idle_cnt_q <= '0;
        terr_q     <= 1'b0;
`endif
      end
`ifdef TIPI_NIB_TIMEOUT_EN
      else if (busy_q && !w_edge && idle_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
        state_q    <= ST_IDLE;
        busy_q     <= 1'b0;
        rx_rd_q    <= '0;
        rx_rc_q    <= '0;
        idle_cnt_q <= '0;
        terr_q     <= 1'b1;
      end
`endif
      else if (w_edge && state_q != ST_IDLE) begin
        state_q <= next_slot(state_q);
`ifdef TIPI_NIB_TIMEOUT_EN
        idle_cnt_q <= '0;
`endif
        case (state_q)
          ST_SLOT4: rx_rd_q[0:3] <= w_nib;
          ST_SLOT5: rx_rd_q[4:7] <= w_nib;
          ST_SLOT6: rx_rc_q[0:3] <= w_nib;
          ST_SLOT7: begin
            // The last nibble goes straight into rc_out so that both bytes
            // update together with the commit pulse.
            rx_rc_q[4:7] <= w_nib;
            rd_q         <= rx_rd_q;
            rc_q         <= {rx_rc_q[0:3], w_nib};
            commit_q     <= 1'b1;
            tx_td_q      <= td_in;
            tx_tc_q      <= tc_in;
          end
          default: ;
        endcase
      end
`ifdef TIPI_NIB_TIMEOUT_EN
      else if (busy_q) begin
        idle_cnt_q <= idle_cnt_q + 16'd1;
      end
`endif
    end
  end

  assign r_nib_out = nib_out_q;
  assign r_nib_oe  = nib_oe_q;
  assign rd_out    = rd_q;
  assign rc_out    = rc_q;
  assign rx_commit = commit_q;
  assign busy      = busy_q;
`ifdef TIPI_NIB_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tipi_nib_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_tipi_nib_seq
// Purpose : Directed self-checking bench for tipi_nib_seq. It drives the Pi
//           strobe, frame reset and nibble bus, and checks the sequencer's
//           outputs against hand-computed values.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tipi_nib_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       r_clk;
  logic       r_nibrst;
  logic [0:3] r_nib_in;
  logic [0:3] r_nib_out;
  logic       r_nib_oe;
  logic [0:7] td_in;
  logic [0:7] tc_in;
  logic [0:7] rd_out;
  logic [0:7] rc_out;
  logic       rx_commit;
  logic       busy;
  logic       timeout_err;

  int n_total  = 0;
  int n_pass   = 0;
  int n_commit = 0;
  int c0;

  tipi_nib_seq #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .r_clk      (r_clk),
    .r_nibrst   (r_nibrst),
    .r_nib_in   (r_nib_in),
    .r_nib_out  (r_nib_out),
    .r_nib_oe   (r_nib_oe),
    .td_in      (td_in),
    .tc_in      (tc_in),
    .rd_out     (rd_out),
    .rc_out     (rc_out),
    .rx_commit  (rx_commit),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Commit pulses are counted on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_commit === 1'b1) n_commit++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic nibrst_pulse();
    r_nibrst = 1'b1;
    tick(4);
    r_nibrst = 1'b0;
    tick(6);
  endtask

  // One full strobe cycle. The nibble is set up well before the rising edge.
  task automatic rclk_edge(input logic [0:3] nib);
    r_nib_in = nib;
    tick(2);
    r_clk = 1'b1;
    tick(5);
    r_clk = 1'b0;
    tick(5);
  endtask

  initial begin
    reset_n  = 1'b0;
    r_clk    = 1'b0;
    r_nibrst = 1'b0;
    r_nib_in = 4'h0;
    td_in    = 8'hA5;
    tc_in    = 8'h3C;
    tick(3);

    // Reset state
    chk("rst_rd",   rd_out, 8'h00);
    chk("rst_rc",   rc_out, 8'h00);
    chk("rst_oe",   r_nib_oe, 1'b0);
    chk("rst_nib",  r_nib_out, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmt",  rx_commit, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    reset_n = 1'b1;
    tick(3);

    // Strobe edges before any frame reset are ignored
    rclk_edge(4'h0);
    rclk_edge(4'h0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_oe",   r_nib_oe, 1'b0);
    chk("idle_nib",  r_nib_out, 4'h0);

    // Full frame: TD=A5, TC=3C out; RD=12, RC=FE in
    nibrst_pulse();
    c0 = n_commit;
    chk("f_busy",  busy, 1'b1);
    chk("f_oe0",   r_nib_oe, 1'b1);
    chk("f_nib0",  r_nib_out, 4'hA);
    rclk_edge(4'h0);
    chk("f_nib1",  r_nib_out, 4'h5);
    rclk_edge(4'h0);
    chk("f_nib2",  r_nib_out, 4'h3);
    rclk_edge(4'h0);
    chk("f_nib3",  r_nib_out, 4'hC);
    rclk_edge(4'h0);
    chk("f_oe4",   r_nib_oe, 1'b0);
    chk("f_nib4",  r_nib_out, 4'h0);
    rclk_edge(4'h1);
    rclk_edge(4'h2);
    rclk_edge(4'hF);
    chk("f_rd_partial", rd_out, 8'h00);
    chk("f_cmt_partial", n_commit - c0, 0);
    rclk_edge(4'hE);
    chk("f_rd",    rd_out, 8'h12);
    chk("f_rc",    rc_out, 8'hFE);
    chk("f_cmt",   n_commit - c0, 1);
    chk("f_wrap_oe",  r_nib_oe, 1'b1);
    chk("f_wrap_nib", r_nib_out, 4'hA);

    // TD changes after SLOT0 entry; the shadow keeps 5A
    td_in = 8'h5A;
    nibrst_pulse();
    chk("snap_nib0", r_nib_out, 4'h5);
    td_in = 8'hFF;
    rclk_edge(4'h0);
    chk("snap_nib1", r_nib_out, 4'hA);
    rclk_edge(4'h0);
    chk("snap_nib2", r_nib_out, 4'h3);
    rclk_edge(4'h0);
    chk("snap_nib3", r_nib_out, 4'hC);

    // Frame reset after six edges; the partial receive is discarded
    c0 = n_commit;
    rclk_edge(4'h0);
    rclk_edge(4'h7);
    rclk_edge(4'h8);
    nibrst_pulse();
    chk("abort_rd",   rd_out, 8'h12);
    chk("abort_rc",   rc_out, 8'hFE);
    chk("abort_cmt",  n_commit - c0, 0);
    chk("abort_busy", busy, 1'b1);
    chk("abort_oe",   r_nib_oe, 1'b1);
    chk("abort_nib",  r_nib_out, 4'hF);

    // 16 continuous edges: two frames, re-snapshot on wrap
    td_in = 8'hC3;
    tc_in = 8'h96;
    nibrst_pulse();
    c0 = n_commit;
    chk("c1_nib0", r_nib_out, 4'hC);
    rclk_edge(4'h0);
    chk("c1_nib1", r_nib_out, 4'h3);
    rclk_edge(4'h0);
    chk("c1_nib2", r_nib_out, 4'h9);
    rclk_edge(4'h0);
    chk("c1_nib3", r_nib_out, 4'h6);
    rclk_edge(4'h0);
    rclk_edge(4'h4);
    rclk_edge(4'h5);
    rclk_edge(4'h6);
    td_in = 8'h0F;
    tc_in = 8'hF0;
    rclk_edge(4'h7);
    chk("c1_rd",   rd_out, 8'h45);
    chk("c1_rc",   rc_out, 8'h67);
    chk("c1_cmt",  n_commit - c0, 1);
    chk("c2_nib0", r_nib_out, 4'h0);
    rclk_edge(4'h0);
    chk("c2_nib1", r_nib_out, 4'hF);
    rclk_edge(4'h0);
    chk("c2_nib2", r_nib_out, 4'hF);
    rclk_edge(4'h0);
    chk("c2_nib3", r_nib_out, 4'h0);
    rclk_edge(4'h0);
    rclk_edge(4'h8);
    rclk_edge(4'h9);
    rclk_edge(4'hA);
    rclk_edge(4'hB);
    chk("c2_rd",   rd_out, 8'h89);
    chk("c2_rc",   rc_out, 8'hAB);
    chk("c2_cmt",  n_commit - c0, 2);

    // Stall in SLOT5
    nibrst_pulse();
    c0 = n_commit;
    rclk_edge(4'h0);
    rclk_edge(4'h0);
    rclk_edge(4'h0);
    rclk_edge(4'h0);
    rclk_edge(4'h3);
    tick(20);
    chk("stall_rd",  rd_out, 8'h89);
    chk("stall_cmt", n_commit - c0, 0);
    chk("stall_oe",  r_nib_oe, 1'b0);
`ifdef TIPI_NIB_TIMEOUT_EN
    chk("to_busy", busy, 1'b0);
    chk("to_terr", timeout_err, 1'b1);
    rclk_edge(4'h0);
    chk("to_idle_busy", busy, 1'b0);
`else
    chk("noto_busy", busy, 1'b1);
    chk("noto_terr", timeout_err, 1'b0);
`endif
    nibrst_pulse();
    chk("clr_terr", timeout_err, 1'b0);
    chk("clr_busy", busy, 1'b1);
    chk("clr_nib",  r_nib_out, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
